// File: rtl/bin2dec_pkg.sv
// Shared types and constants for the binary-to-BCD (Bi2Dec) path.
package bin2dec_pkg;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  localparam int BCD_W = 4;
  localparam int SUB_W = 9;
  localparam logic [8:0] TEN = 9'd10;
endpackage

// File: rtl/fs_9.sv
// 9-bit ripple subtractor: out = a - b - cin, cout is the final borrow.
module FS_9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       cin,
  output logic [8:0] out,
  output logic       cout
);
  logic [9:0] brw;

  assign brw[0] = cin;
  for (genvar i = 0; i < 9; i++) begin : g_cell
    assign out[i]   = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end
  assign cout = brw[9];
endmodule

// File: rtl/bin2bcd_div10.sv
// Sequential binary-to-BCD converter: repeated restoring divide-by-ten,
// one quotient bit per clock, remainders shifted in as BCD digits.
module bin2bcd_div10
  import bin2dec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      ovf
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DW = $clog2(DIGITS + 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] w, w_next;
  logic [BCD_W-1:0]      rem, rem_next;
  logic [CW-1:0]         bit_cnt;
  logic [DW-1:0]         dig_cnt;
  logic [4:0]            r5;
  logic [SUB_W-1:0]      sub_a, diff;
  logic                  borrow, last_bit, last_dig;
  logic                  unused_hi;

  assign r5    = {rem, w[DATA_WIDTH-1]};
  assign sub_a = {{(SUB_W-5){1'b0}}, r5};

  FS_9 u_fs (
    .a    (sub_a),
    .b    (TEN),
    .cin  (1'b0),
    .out  (diff),
    .cout (borrow)
  );

  // borrow means r5 < 10: keep the partial remainder, quotient bit is 0
  assign rem_next  = borrow ? r5[3:0] : diff[3:0];
  assign w_next    = {w[DATA_WIDTH-2:0], ~borrow};
  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign last_dig  = (dig_cnt == DW'(DIGITS - 1));
  assign unused_hi = &{1'b0, diff[8:4]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)            state_nxt = DIV;
      DIV:     if (last_bit && last_dig) state_nxt = DONE;
      DONE:    if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w       <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      dig_cnt <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          w       <= bin_in;
          rem     <= '0;
          bit_cnt <= '0;
          dig_cnt <= '0;
          bcd     <= '0;
          ovf     <= 1'b0;
        end
        DIV: begin
          w <= w_next;
          if (last_bit) begin
            // w now holds the quotient and becomes the next dividend
            bcd     <= {rem_next, bcd[BCD_W*DIGITS-1:BCD_W]};
            rem     <= '0;
            bit_cnt <= '0;
            dig_cnt <= dig_cnt + 1'b1;
            if (last_dig) ovf <= |w_next;
          end else begin
            rem     <= rem_next;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_div10.sv
// Directed scoreboard bench for bin2bcd_div10 (5-digit and 4-digit builds).
module tb_bin2bcd_div10;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [15:0] bin_in;
  logic [19:0] bcd;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, ovf4;
  logic [15:0] bin_in4;
  logic [15:0] bcd4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bin2bcd_div10 #(.DATA_WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .ovf(ovf)
  );

  bin2bcd_div10 #(.DATA_WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .bin_in(bin_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .bcd(bcd4), .ovf(ovf4)
  );

  function automatic exp_t model(input int unsigned v, input int nd);
    exp_t e;
    int unsigned x;
    x = v;
    e.bcd = '0;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.ovf = (x != 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input bit sel, input bit iv, input logic [15:0] v);
    if (sel) begin in_valid4 = iv; bin_in4 = v; end
    else     begin in_valid  = iv; bin_in  = v; end
  endtask

  task automatic drive_ordy(input bit sel, input bit r);
    if (sel) out_ready4 = r;
    else     out_ready  = r;
  endtask

  function automatic logic o_vld(input bit sel);
    return sel ? out_valid4 : out_valid;
  endfunction
  function automatic logic o_rdy(input bit sel);
    return sel ? in_ready4 : in_ready;
  endfunction
  function automatic logic [19:0] o_bcd(input bit sel);
    return sel ? {4'h0, bcd4} : bcd;
  endfunction
  function automatic logic o_ovf(input bit sel);
    return sel ? ovf4 : ovf;
  endfunction

  // Called at a negedge; returns at the negedge right after the DONE handshake.
  task automatic run(input bit sel, input int unsigned v, input int hold,
                     input bit pulse, input string tag);
    int   nd, cyc;
    exp_t e;
    nd = sel ? 4 : 5;
    check({tag, " in_ready"}, 32'(o_rdy(sel)), 32'd1);
    drive_in(sel, 1'b1, 16'(v));
    sb.push_back(model(v, nd));
    @(negedge clk);
    drive_in(sel, 1'b0, 16'h0);
    cyc = 0;
    while (!o_vld(sel) && cyc < 300) begin
      if (pulse && cyc == 10) drive_in(sel, 1'b1, 16'h1111);
      else                    drive_in(sel, 1'b0, 16'h0);
      @(negedge clk);
      cyc++;
    end
    drive_in(sel, 1'b0, 16'h0);
    check({tag, " latency"}, 32'(cyc), 32'(nd * 16));
    e = sb.pop_front();
    check({tag, " bcd"}, 32'(o_bcd(sel)), 32'(e.bcd));
    check({tag, " ovf"}, 32'(o_ovf(sel)), 32'(e.ovf));
    for (int h = 0; h < hold; h++) begin
      drive_in(sel, pulse, 16'd999);
      @(negedge clk);
      check({tag, " hold valid"}, 32'(o_vld(sel)), 32'd1);
      check({tag, " hold bcd"}, 32'(o_bcd(sel)), 32'(e.bcd));
      check({tag, " hold in_ready"}, 32'(o_rdy(sel)), 32'd0);
    end
    drive_in(sel, 1'b0, 16'h0);
    drive_ordy(sel, 1'b1);
    @(negedge clk);
    drive_ordy(sel, 1'b0);
    check({tag, " post valid"}, 32'(o_vld(sel)), 32'd0);
    check({tag, " post bcd"}, 32'(o_bcd(sel)), 32'(e.bcd));
    check({tag, " post ovf"}, 32'(o_ovf(sel)), 32'(e.ovf));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 0;  bin_in = 0;  out_ready = 0;
    in_valid4 = 0; bin_in4 = 0; out_ready4 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

    run(1'b0, 0, 0, 1'b0, "zero");
    run(1'b0, 65535, 0, 1'b0, "max");
    run(1'b0, 10, 0, 1'b0, "ten");
    run(1'b0, 9, 0, 1'b0, "nine");
    run(1'b0, 1234, 5, 1'b1, "stall");

    // abort a conversion mid-DIV
    check("abort in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; bin_in = 16'd777;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready post", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort bcd", 32'(bcd), 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no result", 32'(seen), 32'd0);
    run(1'b0, 4096, 0, 1'b0, "after abort");

    run(1'b1, 12345, 0, 1'b0, "d4 ovf");
    run(1'b1, 9999, 0, 1'b0, "d4 max");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
